// File: rtl/pwm_ramp_if.sv
// Register bus between the CPU and the pwm_ramp soft-start block.
// The CPU side drives select, data and strobe; the block returns readback.
interface pwm_ramp_if;
  logic        A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;

  modport master (
    output A,
    output WD,
    output WE,
    input  RD
  );

  modport slave (
    input  A,
    input  WD,
    input  WE,
    output RD
  );
endinterface

// File: rtl/pwm_ramp.sv
// Soft-start duty slewer feeding the pwm peripheral write port.
// Moves live duty toward a CPU target one STEP per interval of pwm periods.
module pwm_ramp #(
  parameter int TICK_DIV = 126_351,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  pwm_ramp_if.slave  bus,
  output logic [6:0] duty_wd,
  output logic       duty_we,
  output logic       busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [6:0] DUTY_MAX = 7'd100;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [7:0]    interval;
  logic [7:0]    int_cnt;
  logic          int_hit;
  logic          int_clr;
  logic          step_en;
  logic [6:0]    target;
  logic [6:0]    cur;
  logic [6:0]    cur_nx;
  logic [6:0]    wd7;
  logic [6:0]    tgt_in;
  logic [7:0]    up_sum;
  logic [7:0]    dn_lim;
  logic [7:0]    dn_val;
  logic [6:0]    up_cur;
  logic [6:0]    dn_cur;
  logic          unused_wd;

  assign unused_wd = &{1'b0, bus.WD[31:8]};

  // Free-running pwm-period tick, independent of bus activity.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign wd7    = bus.WD[6:0];
  assign tgt_in = (wd7 > DUTY_MAX) ? DUTY_MAX : wd7;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target   <= '0;
      interval <= 8'd1;
    end else if (bus.WE) begin
      if (bus.A) begin
        interval <= bus.WD[7:0];
      end else begin
        target <= tgt_in;
      end
    end
  end

  assign busy   = (state != IDLE) || (cur != target);
  assign bus.RD = bus.A ? {24'b0, interval}
                        : {busy, 24'b0, target};

  // >= rather than == so a shrunk interval mid-ramp cannot stall.
  assign int_hit = (int_cnt >= interval - 8'd1);
  assign step_en = (state != IDLE) &&
                   ((interval == 8'd0) || (tick && int_hit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_cnt <= '0;
    end else if (int_clr) begin
      int_cnt <= '0;
    end else if ((state != IDLE) && tick && (interval != 8'd0)) begin
      int_cnt <= int_hit ? 8'd0 : int_cnt + 8'd1;
    end
  end

  // 8-bit math keeps the clamp free of wrap at both ends.
  assign up_sum = {1'b0, cur} + STEP8;
  assign dn_lim = {1'b0, target} + STEP8;
  assign dn_val = {1'b0, cur} - STEP8;
  assign up_cur = (up_sum >= {1'b0, target}) ? target : up_sum[6:0];
  assign dn_cur = ({1'b0, cur} <= dn_lim) ? target : dn_val[6:0];

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    int_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cur != target) begin
          if (interval == 8'd0) begin
            cur_nx = target;
          end else begin
            state_nx = (cur < target) ? UP : DOWN;
            int_clr  = 1'b1;
          end
        end
      end
      UP, DOWN: begin
        if (cur == target) begin
          state_nx = IDLE;
        end else begin
          state_nx = (cur < target) ? UP : DOWN;
          if (step_en) begin
            unique case (1'b1)
              interval == 8'd0: cur_nx = target;
              cur < target:     cur_nx = up_cur;
              default:          cur_nx = dn_cur;
            endcase
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
    end
  end

  // One-cycle strobe the cycle after cur takes a new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_wd <= '0;
      duty_we <= 1'b0;
    end else begin
      duty_we <= (cur != duty_wd);
      if (cur != duty_wd) begin
        duty_wd <= cur;
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp with a short tick divider.
// Covers reset, register vectors, ramps, clamp, reversal and immediate mode.
module tb_pwm_ramp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_ramp_if bus ();
  pwm_ramp_if bus3 ();

  logic [6:0] duty_wd;
  logic [6:0] duty_wd3;
  logic       duty_we;
  logic       duty_we3;
  logic       busy;
  logic       busy3;

  pwm_ramp #(.TICK_DIV(10), .STEP(1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .duty_wd(duty_wd), .duty_we(duty_we), .busy(busy)
  );

  pwm_ramp #(.TICK_DIV(10), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .duty_wd(duty_wd3), .duty_we(duty_we3), .busy(busy3)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sq_v[$];
  int sq_t[$];
  int sq_b[$];
  int s3_v[$];
  int exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (duty_we) begin
      sq_v.push_back(int'(duty_wd));
      sq_t.push_back(cyc);
      sq_b.push_back(int'(busy));
    end
    if (duty_we3) s3_v.push_back(int'(duty_wd3));
  end

  typedef struct {
    logic        a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [6:0]  exp_duty;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wr(logic a, logic [31:0] d);
    @(negedge clk);
    bus.A  = a;
    bus.WD = d;
    bus.WE = 1'b1;
    @(negedge clk);
    bus.WE = 1'b0;
  endtask

  task automatic wait_idle(string nm, int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_strobe(string nm, int v, int lim);
    int n = 0;
    while (!(duty_we && duty_wd == 7'(v)) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_seen"}, int'(duty_we && duty_wd == 7'(v)), 1);
  endtask

  task automatic chk_seq(string nm, bit three);
    int got[$];
    got = three ? s3_v : sq_v;
    chk({nm, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", nm, i), got[i], exp_q[i]);
  endtask

  task automatic clr_q();
    sq_v.delete();
    sq_t.delete();
    sq_b.delete();
    s3_v.delete();
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'd0,          32'd0,   7'd0};
    vecs[1] = '{1'b0, 32'd120,        32'd100, 7'd100};
    vecs[2] = '{1'b0, 32'd200,        32'd72,  7'd72};
    vecs[3] = '{1'b0, 32'hFFFF_FF32,  32'd50,  7'd50};
    vecs[4] = '{1'b0, 32'd0,          32'd0,   7'd0};
    vecs[5] = '{1'b1, 32'h0000_01FF,  32'd255, 7'd0};
    vecs[6] = '{1'b1, 32'd3,          32'd3,   7'd0};
    vecs[7] = '{1'b1, 32'd1,          32'd1,   7'd0};

    bus.A = 1'b0; bus.WD = '0; bus.WE = 1'b0;
    bus3.A = 1'b0; bus3.WD = '0; bus3.WE = 1'b0;

    // reset state, then async reset mid-clock
    repeat (2) @(negedge clk);
    bus.A = 1'b1;
    #1;
    chk("rst_interval", int'(bus.RD), 1);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    wr(1'b1, 32'd0);
    wr(1'b0, 32'd30);
    wr(1'b1, 32'd7);
    repeat (3) @(negedge clk);
    chk("pre_rst_duty", int'(duty_wd), 30);
    bus.A = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_duty_wd", int'(duty_wd), 0);
    chk("arst_duty_we", int'(duty_we), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_interval", int'(bus.RD), 1);
    @(negedge clk);
    rst = 1'b0;

    // register vectors in immediate mode
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].a, vecs[i].wd);
      repeat (4) @(negedge clk);
      bus.A = vecs[i].a;
      #1;
      chk($sformatf("vec%0d_rd", i), int'(bus.RD), int'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_duty", i), int'(duty_wd), int'(vecs[i].exp_duty));
    end

    // immediate mode 0 -> 60
    wr(1'b1, 32'd0);
    repeat (2) @(negedge clk);
    clr_q();
    bus.A = 1'b0; bus.WD = 32'd60; bus.WE = 1'b1;
    @(negedge clk);
    bus.WE = 1'b0;
    chk("imm_busy_hi", int'(busy), 1);
    @(negedge clk);
    chk("imm_busy_lo", int'(busy), 0);
    chk("imm_we_early", int'(duty_we), 0);
    @(negedge clk);
    chk("imm_we", int'(duty_we), 1);
    chk("imm_wd", int'(duty_wd), 60);
    @(negedge clk);
    chk("imm_we_off", int'(duty_we), 0);
    repeat (5) @(negedge clk);
    chk("imm_count", sq_v.size(), 1);

    // ramp 0 -> 5 at interval 1
    wr(1'b0, 32'd0);
    repeat (4) @(negedge clk);
    wr(1'b1, 32'd1);
    repeat (2) @(negedge clk);
    clr_q();
    wr(1'b0, 32'd5);
    wait_idle("up5", 200);
    exp_q = '{1, 2, 3, 4, 5};
    chk_seq("up5", 1'b0);
    for (int i = 1; i < 5 && i < sq_t.size(); i++)
      chk($sformatf("up5_gap%0d", i), sq_t[i] - sq_t[i-1], 10);
    if (sq_b.size() == 5) begin
      chk("up5_busy4", sq_b[3], 1);
      chk("up5_busy5", sq_b[4], 0);
    end

    // clamp to 100, then down to 97
    wr(1'b0, 32'd120);
    bus.A = 1'b0;
    #1;
    chk("clamp_tgt", int'(bus.RD[6:0]), 100);
    chk("clamp_busy", int'(bus.RD[31]), 1);
    wait_idle("up100", 1500);
    chk("up100_duty", int'(duty_wd), 100);
    clr_q();
    wr(1'b0, 32'd97);
    wait_idle("dn97", 200);
    exp_q = '{99, 98, 97};
    chk_seq("dn97", 1'b0);

    // reversal mid-ramp
    wr(1'b1, 32'd0);
    wr(1'b0, 32'd0);
    repeat (4) @(negedge clk);
    wr(1'b1, 32'd1);
    repeat (2) @(negedge clk);
    clr_q();
    wr(1'b0, 32'd10);
    wait_strobe("rev4", 4, 200);
    wr(1'b0, 32'd2);
    wait_idle("rev", 200);
    exp_q = '{1, 2, 3, 4, 3, 2};
    chk_seq("rev", 1'b0);

    // STEP=3 ramp 0 -> 8
    @(negedge clk);
    bus3.A = 1'b0; bus3.WD = 32'd8; bus3.WE = 1'b1;
    @(negedge clk);
    bus3.WE = 1'b0;
    for (int n = 0; n < 200 && busy3; n++) @(negedge clk);
    chk("s3_idle", int'(busy3), 0);
    repeat (3) @(negedge clk);
    exp_q = '{3, 6, 8};
    chk_seq("s3", 1'b1);

    // reset mid-ramp
    wr(1'b1, 32'd0);
    wr(1'b0, 32'd0);
    repeat (4) @(negedge clk);
    wr(1'b1, 32'd1);
    repeat (2) @(negedge clk);
    clr_q();
    wr(1'b0, 32'd9);
    wait_strobe("mid3", 3, 200);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_cnt_rel", sq_v.size(), 3);
    bus.A = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_no_strobe", sq_v.size(), 3);
    chk("mid_rd_tgt", int'(bus.RD), 0);
    chk("mid_duty", int'(duty_wd), 0);
    bus.A = 1'b1;
    #1;
    chk("mid_interval", int'(bus.RD), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
